// File: rtl/gg_nal_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : gg_nal_byte_packer
// Purpose  : Annex-B byte stream to RBSP word packer with NAL boundary flags
//            and a 4-byte lookahead window.
// Revision : 1.0 - initial release
// ============================================================================
module gg_nal_byte_packer #(
  parameter  int WID      = 32,
  localparam int BYTE_WID = WID / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_byte,
  input  logic                in_flush,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WID-1:0]      out_bits,
  output logic [31:0]         out_pad,
  output logic [BYTE_WID-1:0] out_nal_start,
  output logic [BYTE_WID-1:0] out_nal_end
);

  localparam int NWIN = BYTE_WID + 4;
  localparam int CW   = $clog2(NWIN + 1);
  localparam logic [CW-1:0] c_cnt_full = CW'(NWIN);
  localparam logic [CW-1:0] c_cnt_bw   = CW'(BYTE_WID);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_PAYLOAD = 2'd1,
    S_ZDRAIN  = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t              r_state, w_state_n;
  logic [1:0]          r_zrun, w_zrun_n, w_zrun_inc;
  logic                r_zpend, w_zpend_n;
  logic                r_tail_vld, w_tail_vld_n;
  logic [7:0]          r_tail, w_tail_n;
  logic                r_hold_vld, w_hold_vld_n;
  logic [7:0]          r_hold, w_hold_n;
  logic                r_hold_st, w_hold_st_n;
  logic                r_next_st, w_next_st_n;
  logic                r_rdy_en;
  logic [NWIN-1:0][7:0] r_win, w_win_n;
  logic [NWIN-1:0]     r_wst, w_wst_n;
  logic [NWIN-1:0]     r_wen, w_wen_n;
  logic [CW-1:0]       r_cnt, w_cnt_n, w_cnt_s;

  logic       w_full, w_acc, w_flush, w_xfer;
  logic       w_kept, w_close, w_rel;
  logic [7:0] w_kbyte;

  assign w_full     = (r_cnt == c_cnt_full) & r_hold_vld;
  assign in_ready   = r_rdy_en & ((r_state == S_SEARCH) | (r_state == S_PAYLOAD)) & ~w_full;
  assign w_acc      = in_valid & in_ready;
  assign w_flush    = in_flush & ~in_valid;
  assign out_valid  = (r_cnt == c_cnt_full) |
                      ((r_state == S_FLUSH) & (r_cnt != '0) & ~r_hold_vld);
  assign w_xfer     = out_valid & out_ready;
  assign w_zrun_inc = (r_zrun == 2'd3) ? 2'd3 : r_zrun + 2'd1;
  assign w_cnt_s    = (r_cnt > c_cnt_bw) ? r_cnt - c_cnt_bw : '0;

  always_comb begin
    w_state_n    = r_state;
    w_zrun_n     = r_zrun;
    w_zpend_n    = r_zpend;
    w_tail_vld_n = r_tail_vld;
    w_tail_n     = r_tail;
    w_next_st_n  = r_next_st;
    w_kept       = 1'b0;
    w_kbyte      = 8'h00;
    w_close      = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_acc) begin
          if (in_byte == 8'h01 && r_zrun[1]) begin
            w_state_n   = S_PAYLOAD;
            w_next_st_n = 1'b1;
            w_zrun_n    = 2'd0;
          end else if (in_byte == 8'h00) begin
            w_zrun_n = w_zrun_inc;
          end else begin
            w_zrun_n = 2'd0;
          end
        end else if (w_flush) begin
          w_state_n = S_FLUSH;
          w_zrun_n  = 2'd0;
        end
      end
      S_PAYLOAD: begin
        if (w_acc) begin
          if (in_byte == 8'h00) begin
            w_zrun_n = w_zrun_inc;
          end else if (in_byte == 8'h01 && r_zrun[1]) begin
            w_close     = 1'b1;
            w_next_st_n = 1'b1;
            w_zrun_n    = 2'd0;
          end else if (r_zrun != 2'd0) begin
            // First pending zero leaves now; the rest (and the byte) follow in ZDRAIN.
            w_kept       = 1'b1;
            w_zrun_n     = 2'd0;
            w_state_n    = S_ZDRAIN;
            w_zpend_n    = r_zrun[1];
            w_tail_vld_n = !(in_byte == 8'h03 && r_zrun == 2'd2);
            w_tail_n     = in_byte;
          end else begin
            w_kept  = 1'b1;
            w_kbyte = in_byte;
          end
        end else if (w_flush) begin
          w_state_n = S_FLUSH;
          w_zrun_n  = 2'd0;
        end
      end
      S_ZDRAIN: begin
        if (!w_full) begin
          w_kept = 1'b1;
          if (r_zpend) begin
            w_zpend_n = 1'b0;
            if (!r_tail_vld) w_state_n = S_PAYLOAD;
          end else begin
            w_kbyte      = r_tail;
            w_tail_vld_n = 1'b0;
            w_state_n    = S_PAYLOAD;
          end
        end
      end
      S_FLUSH: begin
        if (r_hold_vld) begin
          if (r_cnt != c_cnt_full) w_close = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_n   = S_SEARCH;
          w_next_st_n = 1'b0;
          w_zrun_n    = 2'd0;
        end
      end
      default: w_state_n = S_SEARCH;
    endcase
    if (w_kept) w_next_st_n = 1'b0;
  end

  // Holding register: its nal_end is only known once the next event arrives.
  always_comb begin
    w_rel        = (w_kept | w_close) & r_hold_vld;
    w_hold_vld_n = r_hold_vld;
    w_hold_n     = r_hold;
    w_hold_st_n  = r_hold_st;
    if (w_kept) begin
      w_hold_vld_n = 1'b1;
      w_hold_n     = w_kbyte;
      w_hold_st_n  = r_next_st;
    end else if (w_close) begin
      w_hold_vld_n = 1'b0;
    end
  end

  always_comb begin
    w_win_n = r_win;
    w_wst_n = r_wst;
    w_wen_n = r_wen;
    w_cnt_n = r_cnt;
    if (w_xfer) begin
      w_win_n = r_win >> (8 * BYTE_WID);
      w_wst_n = r_wst >> BYTE_WID;
      w_wen_n = r_wen >> BYTE_WID;
      w_cnt_n = w_cnt_s;
    end
    if (w_rel) begin
      for (int i = 0; i < NWIN; i++) begin
        if (CW'(i) == w_cnt_n) begin
          w_win_n[i] = r_hold;
          w_wst_n[i] = r_hold_st;
          w_wen_n[i] = w_close;
        end
      end
      w_cnt_n = w_cnt_n + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_SEARCH;
      r_zrun     <= 2'd0;
      r_zpend    <= 1'b0;
      r_tail_vld <= 1'b0;
      r_tail     <= 8'h00;
      r_hold_vld <= 1'b0;
      r_hold     <= 8'h00;
      r_hold_st  <= 1'b0;
      r_next_st  <= 1'b0;
      r_rdy_en   <= 1'b0;
      r_win      <= '0;
      r_wst      <= '0;
      r_wen      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_zrun     <= w_zrun_n;
      r_zpend    <= w_zpend_n;
      r_tail_vld <= w_tail_vld_n;
      r_tail     <= w_tail_n;
      r_hold_vld <= w_hold_vld_n;
      r_hold     <= w_hold_n;
      r_hold_st  <= w_hold_st_n;
      r_next_st  <= w_next_st_n;
      r_rdy_en   <= 1'b1;
      r_win      <= w_win_n;
      r_wst      <= w_wst_n;
      r_wen      <= w_wen_n;
      r_cnt      <= w_cnt_n;
    end
  end

  always_comb begin
    out_bits      = '0;
    out_pad       = '0;
    out_nal_start = '0;
    out_nal_end   = '0;
    for (int i = 0; i < BYTE_WID; i++) begin
      out_bits[WID-1-8*i -: 8]   = r_win[i];
      out_nal_start[BYTE_WID-1-i] = r_wst[i];
      out_nal_end[BYTE_WID-1-i]   = r_wen[i];
    end
    for (int i = 0; i < 4; i++) begin
      out_pad[31-8*i -: 8] = r_win[BYTE_WID+i];
    end
  end

endmodule
`default_nettype wire

// File: doc/gg_nal_byte_packer.md
GG_NAL_BYTE_PACKER -- requirements
Module: gg_nal_byte_packer

Interface
REQ-001 SHALL have parameter WID, default 32, meaning output word width in bits (multiple of 8, 32..128).
REQ-002 SHALL derive BYTE_WID = WID/8, the bytes per output word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning in_byte holds a stream byte.
REQ-006 SHALL have port in_byte, input, 8, meaning the next Annex-B byte-stream byte.
REQ-007 SHALL have port in_flush, input, 1, meaning end of stream, sampled only when in_valid=0.
REQ-008 SHALL have port in_ready, output, 1, meaning a byte is accepted when in_valid&in_ready.
REQ-009 SHALL have port out_valid, output, 1, meaning a word is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning a word is taken when out_valid&out_ready.
REQ-011 SHALL have port out_bits, output, WID, meaning RBSP bits, first byte in [WID-1:WID-8].
REQ-012 SHALL have port out_pad, output, 32, meaning the next 4 RBSP bytes (lookahead), first in [31:24], zero past stream end.
REQ-013 SHALL have ports out_nal_start and out_nal_end, output, BYTE_WID each, meaning the byte is the first/last of a NAL, bit [BYTE_WID-1] = first byte.

Function
REQ-014 SHALL run FSM states SEARCH (discard until start code), PAYLOAD, ZDRAIN (emit pending zeros), FLUSH.
REQ-015 SHALL keep zrun, a saturating count 0..3 of consecutive 0x00 bytes accepted in PAYLOAD/SEARCH.
REQ-016 SHALL in SEARCH treat 0x01 with zrun>=2 as start code: go PAYLOAD, flag next kept byte nal_start, drop all start-code bytes.
REQ-017 SHALL in PAYLOAD drop 0x03 with zrun==2 (emulation prevention) after emitting two 0x00 bytes, then clear zrun.
REQ-018 SHALL in PAYLOAD treat 0x01 with zrun>=2 as a new start code: drop the zeros, flag the held byte nal_end, and flag the next kept byte nal_start.
REQ-019 SHALL, on any other nonzero byte with zrun>0, enter ZDRAIN, emit min(zrun,2) zeros one per cycle with in_ready=0, then emit the byte.
REQ-020 SHALL hold the last kept byte in a one-byte holding register until the next kept byte, start code, or flush decides its nal_end flag.
REQ-021 SHALL append released bytes to a window of BYTE_WID+4 bytes with per-byte start/end flags and a byte count.
REQ-022 SHALL assert out_valid when count==BYTE_WID+4, or in FLUSH when count>0.
REQ-023 SHALL, on transfer, shift the window by BYTE_WID bytes and reduce count by min(count,BYTE_WID); an append in the same cycle lands after the shift.
REQ-024 SHALL zero-fill unused window bytes and flags, so out_pad and partial words read 0.
REQ-025 SHALL derive in_ready from registered state only: 1 iff state!=ZDRAIN and window plus holding register not full; no combinational path from out_ready.
REQ-026 SHALL keep out_* stable while out_valid&!out_ready.
REQ-027 SHALL on in_flush release the held byte with nal_end=1, drop pending zeros, drain words, then return to SEARCH with count=0 and zrun=0.
REQ-028 SHALL have a latency from byte acceptance to word presentation of at most BYTE_WID+6 cycles, given no backpressure.

Reset
REQ-029 SHALL, while reset=0, force state=SEARCH, zrun=0, count=0, holding register empty, out_valid=0, out_bits=0, out_pad=0, out_nal_start=0, out_nal_end=0, and in_ready=0.
REQ-030 SHALL drive in_ready=1 on the first clk edge after reset rises, and SHALL discard any partial word on a mid-stream reset.

Verification
REQ-031 SHALL cover: WID=32, bytes 00 00 00 01 27 42 E0 2A F7 16 26 20 + flush -> word0 out_bits=0x2742E02A, out_pad=0xF7162620, out_nal_start=4'b1000.
REQ-032 SHALL cover: 00 00 01 21 00 00 03 01 AA BB + flush -> out_bits=0x21000001, out_pad=0xAABB0000, out_nal_end=0 for word0; word1 out_bits=0xAABB0000, out_nal_end=4'b0100.
REQ-033 SHALL cover: 00 00 01 28 CA 8F 20 00 00 00 01 21 E4 -> 0x20 byte flagged nal_end, 0x21 flagged nal_start, trailing zeros absent.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with word pending -> out_* unchanged, in_ready falls once window and holding register full, no byte lost.
REQ-035 SHALL cover: reset asserted after 6 payload bytes -> out_valid=0 same cycle, and the next stream starts clean with nal_start on its first byte.
REQ-036 SHALL cover: 00 00 01 AB 00 00 00 CD (zrun saturates) -> emitted RBSP AB 00 00 CD, in_ready low for 2 cycles during ZDRAIN.
